// File: rtl/board_io_ctrl.sv
// Board I/O controller: synchronised switches, debounced pushbuttons, an LED register and a
// small register bus with a pending/mask interrupt. Macro BOARD_IO_SWIRQ_EN adds a switch-change event at PEND[BTN_NUM].
module board_io_ctrl #(
    parameter int SW_WIDTH        = 16,
    parameter int LED_WIDTH       = 16,
    parameter int BTN_NUM         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [BTN_NUM-1:0]   btn_i,
    input  logic [SW_WIDTH-1:0]  sw_i,
    output logic [LED_WIDTH-1:0] led_o,
    input  logic                 bus_req_i,
    input  logic                 bus_we_i,
    input  logic [2:0]           bus_addr_i,
    input  logic [31:0]          bus_wdata_i,
    output logic                 bus_ack_o,
    output logic [31:0]          bus_rdata_o,
    output logic                 irq_o
);

`ifdef BOARD_IO_SWIRQ_EN
    localparam int          IRQ_W  = BTN_NUM + 1;
    localparam logic [7:0]  ID_TAG = 8'h11;
`else
    localparam int          IRQ_W  = BTN_NUM;
    localparam logic [7:0]  ID_TAG = 8'h10;
`endif
    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     ID_VAL  = {ID_TAG, 8'(BTN_NUM), 8'(SW_WIDTH), 8'(LED_WIDTH)};

    logic [BTN_NUM-1:0]   r_btn_meta, r_btn_sync, r_btn_lvl;
    logic [SW_WIDTH-1:0]  r_sw_meta, r_sw_sync;
    logic [CNT_W-1:0]     r_cnt [BTN_NUM];
    logic [LED_WIDTH-1:0] r_led;
    logic [IRQ_W-1:0]     r_pend, r_mask;
    logic                 r_ack;
    logic [31:0]          r_rdata;

    logic [BTN_NUM-1:0]   w_hit, w_rise;
    logic [IRQ_W-1:0]     w_evt, w_pend_clr;
    logic                 w_wr_en;
    logic [31:0]          w_rd_data;
    logic                 w_unused;

    assign w_unused = ^bus_wdata_i;
    assign w_wr_en  = bus_req_i & bus_we_i;

    // Two-flop synchronisers for every raw board input
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_meta <= '0;
            r_btn_sync <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
        end else begin
            r_btn_meta <= btn_i;
            r_btn_sync <= r_btn_meta;
            r_sw_meta  <= sw_i;
            r_sw_sync  <= r_sw_meta;
        end
    end

`ifdef BOARD_IO_SWIRQ_EN
    logic [SW_WIDTH-1:0] r_sw_prev;

    // Previous synced switch sample for change detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_prev <= '0;
        end else begin
            r_sw_prev <= r_sw_sync;
        end
    end

    assign w_evt = {|(r_sw_sync ^ r_sw_prev), w_rise};
`else
    assign w_evt = w_rise;
`endif

    // Debounce acceptance: the counter has seen DEBOUNCE_CYCLES-1 differing cycles already
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < BTN_NUM; k++) begin
            w_hit[k] = (r_btn_sync[k] != r_btn_lvl[k]) && (r_cnt[k] == CNT_MAX);
        end
        w_rise = w_hit & ~r_btn_lvl;
    end

    // Per-button debounce counters and accepted levels
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_btn_lvl <= '0;
            for (int k = 0; k < BTN_NUM; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < BTN_NUM; k++) begin
                if (r_btn_sync[k] != r_btn_lvl[k]) begin
                    if (w_hit[k]) begin
                        r_btn_lvl[k] <= ~r_btn_lvl[k];
                        r_cnt[k]     <= '0;
                    end else begin
                        r_cnt[k]     <= r_cnt[k] + CNT_W'(1);
                    end
                end else begin
                    r_cnt[k] <= '0;
                end
            end
        end
    end

    // Read mux over the current register contents; unimplemented bits stay zero
    always_comb begin
        w_rd_data = 32'd0;
        case (bus_addr_i)
            3'd0:    w_rd_data[LED_WIDTH-1:0] = r_led;
            3'd1:    w_rd_data[SW_WIDTH-1:0]  = r_sw_sync;
            3'd2:    w_rd_data[BTN_NUM-1:0]   = r_btn_lvl;
            3'd3:    w_rd_data[IRQ_W-1:0]     = r_pend;
            3'd4:    w_rd_data[IRQ_W-1:0]     = r_mask;
            3'd5:    w_rd_data                = ID_VAL;
            default: w_rd_data                = 32'd0;
        endcase
    end

    // W1C clear vector for the pending register
    always_comb begin
        if (w_wr_en && (bus_addr_i == 3'd3)) begin
            w_pend_clr = bus_wdata_i[IRQ_W-1:0];
        end else begin
            w_pend_clr = '0;
        end
    end

    // Bus registers; event set is OR-ed after the clear so a simultaneous set wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_led   <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_ack   <= bus_req_i;
            r_rdata <= (bus_req_i && !bus_we_i) ? w_rd_data : 32'd0;
            r_pend  <= (r_pend & ~w_pend_clr) | w_evt;
            if (w_wr_en && (bus_addr_i == 3'd0)) begin
                r_led <= bus_wdata_i[LED_WIDTH-1:0];
            end
            if (w_wr_en && (bus_addr_i == 3'd4)) begin
                r_mask <= bus_wdata_i[IRQ_W-1:0];
            end
        end
    end

    assign led_o       = r_led;
    assign bus_ack_o   = r_ack;
    assign bus_rdata_o = r_rdata;
    assign irq_o       = |(r_pend & r_mask);

endmodule
